// File: rtl/reg_list_sequencer.sv
// LDM/STM block-transfer sequencer: walks a 16-bit register list, one register per memory beat.
// Optional feature: define USER_BANK_EN to let the latched user_bank flag force user-mode M during XFER.
module reg_list_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic [15:0]       reg_list,
  input  logic [4:0]        cur_mode,
  input  logic              user_bank,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] r_data_a,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        r_addr_a,
  output logic [3:0]        w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              write_reg,
  output logic              write_pc,
  output logic [DATA_W-1:0] pc_data,
  output logic [4:0]        M,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_e;

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic              load_q, load_d;
  logic              do_wb_q, do_wb_d;
  logic [3:0]        base_reg_q, base_reg_d;

  logic [4:0]        n;
  logic [ADDR_W-1:0] four_n;
  logic [3:0]        idx;
  logic              last_beat;

  assign n         = popcount16(reg_list);
  assign four_n    = ADDR_W'({n, 2'b00});
  assign idx       = lowest_set(list_q);
  assign last_beat = ((list_q & (list_q - 16'd1)) == 16'd0);

`ifdef USER_BANK_EN
  logic ub_q, ub_d;
`else
  logic unused_user_bank;
  assign unused_user_bank = user_bank;
`endif

  // NOTE: every output and next-state variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    final_d    = final_q;
    load_d     = load_q;
    do_wb_d    = do_wb_q;
    base_reg_d = base_reg_q;
`ifdef USER_BANK_EN
    ub_d       = ub_q;
`endif
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    r_addr_a   = '0;
    w_addr     = '0;
    w_data     = '0;
    write_reg  = 1'b0;
    write_pc   = 1'b0;
    pc_data    = '0;
    M          = cur_mode;
    busy       = (state_q != IDLE);
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          list_d     = reg_list;
          load_d     = is_load;
          base_reg_d = base_reg;
          final_d    = up ? base_val + four_n : base_val - four_n;
          // Decrementing modes still walk upward: start at the lowest word of the block.
          unique case ({up, pre})
            2'b10:   addr_d = base_val;
            2'b11:   addr_d = base_val + WORD;
            2'b00:   addr_d = base_val - four_n + WORD;
            default: addr_d = base_val - four_n;
          endcase
          // An empty list never touches the base; a loaded base keeps the loaded value.
          do_wb_d = writeback && (n != 5'd0) && !(is_load && reg_list[base_reg]);
`ifdef USER_BANK_EN
          ub_d    = user_bank;
`endif
          state_d = (n != 5'd0) ? XFER : WB;
        end
      end
      XFER: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (load_q) begin
          if (mem_ready) begin
            if (idx == 4'd15) begin
              write_pc = 1'b1;
              pc_data  = mem_rdata;
            end else begin
              write_reg = 1'b1;
              w_addr    = idx;
              w_data    = mem_rdata;
            end
          end
        end else begin
          mem_we    = 1'b1;
          r_addr_a  = idx;
          mem_wdata = r_data_a;
        end
`ifdef USER_BANK_EN
        if (ub_q) M = 5'b10000;
`endif
        if (mem_ready) begin
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + WORD;
          if (last_beat) state_d = WB;
        end
      end
      WB: begin
        if (do_wb_q) begin
          write_reg = 1'b1;
          w_addr    = base_reg_q;
          w_data    = DATA_W'(final_q);
        end
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      list_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      load_q     <= 1'b0;
      do_wb_q    <= 1'b0;
      base_reg_q <= '0;
`ifdef USER_BANK_EN
      ub_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      load_q     <= load_d;
      do_wb_q    <= do_wb_d;
      base_reg_q <= base_reg_d;
`ifdef USER_BANK_EN
      ub_q       <= ub_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_list_sequencer.sv
// Directed self-checking bench for reg_list_sequencer; expected values are hand-computed per step.
module tb_reg_list_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_load, up, pre, writeback, user_bank, mem_ready;
  logic [3:0]  base_reg;
  logic [31:0] base_val, mem_rdata, r_data_a;
  logic [15:0] reg_list;
  logic [4:0]  cur_mode;
  logic        mem_req, mem_we, write_reg, write_pc, busy, done;
  logic [31:0] mem_addr, mem_wdata, w_data, pc_data;
  logic [3:0]  r_addr_a, w_addr;
  logic [4:0]  M;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register-file stand-in: register i reads as 0x11*i.
  assign r_data_a = 32'h11 * {28'h0, r_addr_a};

  reg_list_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .up(up), .pre(pre),
    .writeback(writeback), .base_reg(base_reg), .base_val(base_val), .reg_list(reg_list),
    .cur_mode(cur_mode), .user_bank(user_bank), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .r_data_a(r_data_a), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .r_addr_a(r_addr_a), .w_addr(w_addr), .w_data(w_data),
    .write_reg(write_reg), .write_pc(write_pc), .pc_data(pc_data), .M(M), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic ld, input logic u, input logic p, input logic wb,
                     input logic [3:0] br, input logic [31:0] bv, input logic [15:0] rl);
    is_load = ld; up = u; pre = p; writeback = wb; base_reg = br; base_val = bv; reg_list = rl;
    start = 1'b1;
    next();
    start = 1'b0;
    #1;
  endtask

  logic [4:0] m_xfer;

  initial begin
    rst = 1'b0; start = 1'b0; is_load = 1'b0; up = 1'b1; pre = 1'b0; writeback = 1'b0;
    base_reg = '0; base_val = '0; reg_list = '0; cur_mode = 5'h13; user_bank = 1'b0;
    mem_ready = 1'b1; mem_rdata = '0;
`ifdef USER_BANK_EN
    m_xfer = 5'h10;
`else
    m_xfer = 5'h13;
`endif
    next();
    check("rst_busy", 32'(busy), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_wreg", 32'(write_reg), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_M", 32'(M), 32'h13);
    rst = 1'b1;
    next();

    // STM IA r1..r3 from 0x100 with writeback into r13
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd13, 32'h100, 16'h000E);
    check("stm_req", 32'(mem_req), 1);
    check("stm_we", 32'(mem_we), 1);
    check("stm_a0", mem_addr, 32'h100);
    check("stm_r0", 32'(r_addr_a), 1);
    check("stm_d0", mem_wdata, 32'h11);
    check("stm_nowr", 32'(write_reg), 0);
    check("stm_busy", 32'(busy), 1);
    next();
    check("stm_a1", mem_addr, 32'h104);
    check("stm_d1", mem_wdata, 32'h22);
    next();
    check("stm_a2", mem_addr, 32'h108);
    check("stm_d2", mem_wdata, 32'h33);
    next();
    check("stm_wb_req", 32'(mem_req), 0);
    check("stm_wb_wr", 32'(write_reg), 1);
    check("stm_wb_addr", 32'(w_addr), 13);
    check("stm_wb_data", w_data, 32'h10C);
    check("stm_wb_done", 32'(done), 0);
    next();
    check("stm_done", 32'(done), 1);
    check("stm_done_busy", 32'(busy), 1);
    next();
    check("stm_idle_done", 32'(done), 0);
    check("stm_idle_busy", 32'(busy), 0);

    // LDM DB r0,r15 below 0x200, writeback into r5
    mem_rdata = 32'hA;
    cmd(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 32'h200, 16'h8001);
    check("ldm_a0", mem_addr, 32'h1F8);
    check("ldm_we0", 32'(mem_we), 0);
    check("ldm_wr0", 32'(write_reg), 1);
    check("ldm_wa0", 32'(w_addr), 0);
    check("ldm_wd0", w_data, 32'hA);
    check("ldm_pc0", 32'(write_pc), 0);
    next();
    mem_rdata = 32'hB;
    #1;
    check("ldm_a1", mem_addr, 32'h1FC);
    check("ldm_pc1", 32'(write_pc), 1);
    check("ldm_pcd1", pc_data, 32'hB);
    check("ldm_wr1", 32'(write_reg), 0);
    next();
    check("ldm_wb_wr", 32'(write_reg), 1);
    check("ldm_wb_addr", 32'(w_addr), 5);
    check("ldm_wb_data", w_data, 32'h1F8);
    next();
    check("ldm_done", 32'(done), 1);
    next();

    // LDM IA with the base register in the list: no writeback
    mem_rdata = 32'h55;
    cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h300, 16'h0004);
    check("ldb_addr", mem_addr, 32'h300);
    check("ldb_wr", 32'(write_reg), 1);
    check("ldb_wa", 32'(w_addr), 2);
    check("ldb_wd", w_data, 32'h55);
    next();
    check("ldb_wb_nowr", 32'(write_reg), 0);
    check("ldb_wb_busy", 32'(busy), 1);
    next();
    check("ldb_done", 32'(done), 1);
    next();

    // Empty list: no beats, no write, done two cycles after start
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 32'h700, 16'h0000);
    check("empty_req", 32'(mem_req), 0);
    check("empty_wr", 32'(write_reg), 0);
    check("empty_done0", 32'(done), 0);
    next();
    check("empty_done", 32'(done), 1);
    check("empty_wr2", 32'(write_reg), 0);
    next();

    // STM IB r4..r7 from 0x400 with wait states on beat 2; a stray start must be ignored
    cmd(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 32'h400, 16'h00F0);
    check("ws_a0", mem_addr, 32'h404);
    check("ws_d0", mem_wdata, 32'h44);
    next();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        base_val = 32'h900; reg_list = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #1;
      check("ws_hold_a", mem_addr, 32'h408);
      check("ws_hold_r", 32'(r_addr_a), 5);
      check("ws_hold_d", mem_wdata, 32'h55);
      next();
    end
    start = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("ws_a1", mem_addr, 32'h408);
    next();
    check("ws_a2", mem_addr, 32'h40C);
    check("ws_r2", 32'(r_addr_a), 6);
    next();
    check("ws_a3", mem_addr, 32'h410);
    next();
    check("ws_wb_nowr", 32'(write_reg), 0);
    next();
    check("ws_done", 32'(done), 1);
    next();

    // LDM DA r0,r1 at 0x500 with a held load beat: no register write while stalled
    mem_ready = 1'b0;
    mem_rdata = 32'h77;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 32'h500, 16'h0003);
    check("lw_addr", mem_addr, 32'h4FC);
    check("lw_req", 32'(mem_req), 1);
    check("lw_nowr", 32'(write_reg), 0);
    mem_ready = 1'b1;
    #1;
    check("lw_wr", 32'(write_reg), 1);
    check("lw_wa", 32'(w_addr), 0);
    next();
    check("lw_a1", mem_addr, 32'h500);
    check("lw_wa1", 32'(w_addr), 1);
    next();
    next();
    check("lw_done", 32'(done), 1);
    next();

    // Reset mid-transfer, then a clean restart with user_bank set
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 32'h800, 16'h0003);
    next();
    check("rm_a1", mem_addr, 32'h804);
    rst = 1'b0;
    #1;
    check("rm_req", 32'(mem_req), 0);
    check("rm_we", 32'(mem_we), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_addr", mem_addr, 0);
    next();
    rst = 1'b1;
    next();
    check("rm_idle", 32'(busy), 0);
    user_bank = 1'b1;
    mem_rdata = 32'h99;
    cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 32'h600, 16'h0002);
    check("ub_addr", mem_addr, 32'h600);
    check("ub_wd", w_data, 32'h99);
    check("ub_M_xfer", 32'(M), 32'(m_xfer));
    next();
    check("ub_M_wb", 32'(M), 32'h13);
    check("ub_wb_data", w_data, 32'h604);
    next();
    check("ub_done", 32'(done), 1);
    next();
    check("ub_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
